// File: rtl/bcd_bin_ctrl.sv
// Packed-BCD to binary converter, MSD first, one digit per clock via acc*10+d.
// Latency: done pulses N_DIG edges after the start edge (busy for N_DIG cycles, then one DONE cycle).
// Backpressure: none; start is ignored while busy, and there is no queuing of requests.
module bcd_bin_ctrl #(
    parameter int N_DIG = 4,
    parameter int W_BIN = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [4*N_DIG-1:0] num_BCD,
    output logic               busy,
    output logic               done,
    output logic [W_BIN-1:0]   num_bin,
    output logic               err
);

    localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int SH_W  = 4 * N_DIG;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SH_W-1:0]    sh_q, sh_d;
    logic [W_BIN-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               err_flag_q, err_flag_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [W_BIN-1:0]   num_bin_q, num_bin_d;
    logic               err_q, err_d;

    logic [3:0]         dig;
    logic [3:0]         dig_add;
    logic               dig_bad;
    logic [W_BIN-1:0]   acc_step;

    // Next-state, datapath step and output values for the following edge
    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        err_flag_d = err_flag_q;
        num_bin_d  = num_bin_q;
        err_d      = err_q;
        done_d     = 1'b0;

        // Single reused multiply-by-ten-and-add step; a non-decimal nibble adds zero
        dig      = sh_q[SH_W-1 -: 4];
        dig_bad  = (dig > 4'd9);
        dig_add  = dig_bad ? 4'd0 : dig;
        acc_step = (acc_q << 3) + (acc_q << 1) + {{(W_BIN-4){1'b0}}, dig_add};

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    sh_d       = num_BCD;
                    acc_d      = '0;
                    idx_d      = IDX_W'(N_DIG - 1);
                    err_flag_d = 1'b0;
                    state_d    = ST_CONV;
                end
            end
            ST_CONV: begin
                acc_d      = acc_step;
                sh_d       = sh_q << 4;
                err_flag_d = err_flag_q | dig_bad;
                if (idx_q == '0) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    num_bin_d = err_flag_d ? '0 : acc_step;
                    err_d     = err_flag_d;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_CONV);
    end

    // State and registered outputs; reset aborts any conversion without a done
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sh_q       <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            err_flag_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            num_bin_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            err_flag_q <= err_flag_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            num_bin_q  <= num_bin_d;
            err_q      <= err_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign num_bin = num_bin_q;
    assign err     = err_q;

endmodule

// File: tb/tb_bcd_bin_ctrl.sv
// Self-checking bench for bcd_bin_ctrl: directed cases plus randomized operands vs. an arithmetic model.
// Latency: checks busy for 4 cycles after the start edge and a single done pulse in the cycle after.
// Backpressure: exercises ignored start during busy, back-to-back start, and reset mid-conversion.
module tb_bcd_bin_ctrl;

    localparam int N_DIG = 4;
    localparam int W_BIN = 14;

    logic               clk;
    logic               rst;
    logic               start;
    logic [4*N_DIG-1:0] num_BCD;
    logic               busy;
    logic               done;
    logic [W_BIN-1:0]   num_bin;
    logic               err;

    int n_checks;
    int n_errors;

    bcd_bin_ctrl #(.N_DIG(N_DIG), .W_BIN(W_BIN)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .num_BCD (num_BCD),
        .busy    (busy),
        .done    (done),
        .num_bin (num_bin),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    // Reference: decimal value by positional weights; any nibble > 9 flags error and forces 0
    function automatic void ref_conv(input logic [15:0] v, output int bin, output bit e);
        int w;
        int d;
        bin = 0;
        e   = 1'b0;
        w   = 1;
        for (int i = 0; i < N_DIG; i++) begin
            d = int'((v >> (4 * i)) & 16'hF);
            if (d > 9) e = 1'b1;
            else       bin = bin + d * w;
            w = w * 10;
        end
        if (e) bin = 0;
    endfunction

    // One conversion with a single-cycle start; optionally pokes start during busy
    task automatic do_conv(input logic [15:0] v, input bit poke, input string tag);
        int  exp_bin;
        bit  exp_err;
        ref_conv(v, exp_bin, exp_err);
        @(negedge clk);
        start   = 1'b1;
        num_BCD = v;
        for (int i = 0; i < N_DIG; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start   = 1'b0;
                num_BCD = 16'($urandom);
            end
            if (poke && i == 1) begin
                start   = 1'b1;
                num_BCD = 16'h5555;
            end
            if (poke && i == 2) start = 1'b0;
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " done_early"}, 32'(done), 32'd0);
        end
        @(negedge clk);
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy_in_done"}, 32'(busy), 32'd0);
        check({tag, " num_bin"}, 32'(num_bin), 32'(exp_bin));
        check({tag, " err"}, 32'(err), 32'(exp_err));
        @(negedge clk);
        check({tag, " done_after"}, 32'(done), 32'd0);
        check({tag, " busy_after"}, 32'(busy), 32'd0);
        check({tag, " num_bin_hold"}, 32'(num_bin), 32'(exp_bin));
        check({tag, " err_hold"}, 32'(err), 32'(exp_err));
    endtask

    initial begin
        logic [15:0] rv;
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        start    = 1'b0;
        num_BCD  = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset num_bin", 32'(num_bin), 32'd0);
        check("reset err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_conv(16'h1234, 1'b0, "c1234");
        do_conv(16'h9999, 1'b0, "c9999");
        do_conv(16'h0000, 1'b0, "c0000");
        do_conv(16'h0007, 1'b0, "c0007");
        do_conv(16'h12A4, 1'b0, "c12A4");
        do_conv(16'h0042, 1'b0, "c0042");
        do_conv(16'h0100, 1'b1, "ignore");
        // Quiet period: no second busy/done from the ignored start
        repeat (6) begin
            @(negedge clk);
            check("ignore no_busy", 32'(busy), 32'd0);
            check("ignore no_done", 32'(done), 32'd0);
        end

        // Back-to-back with start held high: 1 then 2, busy low only in DONE cycles
        @(negedge clk);
        start   = 1'b1;
        num_BCD = 16'h0001;
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < N_DIG; i++) begin
                @(negedge clk);
                if (i == 0) num_BCD = 16'h0002;
                check("b2b busy", 32'(busy), 32'd1);
                check("b2b done_early", 32'(done), 32'd0);
            end
            @(negedge clk);
            check("b2b done", 32'(done), 32'd1);
            check("b2b busy_in_done", 32'(busy), 32'd0);
            check("b2b num_bin", 32'(num_bin), 32'(rep + 1));
            check("b2b err", 32'(err), 32'd0);
            if (rep == 1) start = 1'b0;
        end
        @(negedge clk);
        check("b2b stop busy", 32'(busy), 32'd0);
        check("b2b stop done", 32'(done), 32'd0);

        // Reset on the third CONV cycle of 0x4321
        @(negedge clk);
        start   = 1'b1;
        num_BCD = 16'h4321;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            check("rstmid busy", 32'(busy), 32'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid busy", 32'(busy), 32'd0);
        check("rstmid done", 32'(done), 32'd0);
        check("rstmid num_bin", 32'(num_bin), 32'd0);
        check("rstmid err", 32'(err), 32'd0);
        repeat (8) begin
            @(negedge clk);
            check("rstmid no_done", 32'(done), 32'd0);
        end
        do_conv(16'h4321, 1'b0, "c4321");

        // Randomized operands, roughly one nibble in six non-decimal
        for (int t = 0; t < 40; t++) begin
            rv = '0;
            for (int n = 0; n < N_DIG; n++)
                rv = rv | (16'($urandom_range(0, 11)) << (4 * n));
            do_conv(rv, ($urandom_range(0, 3) == 0), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
